// File: rtl/cpu_pkg.sv
// Shared ISA constants, ALU operation encoding and pipeline-register layouts
// for the five-stage cpu core.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluSlt
    } alu_op_e;

    typedef struct packed {
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        alu_op_e     alu_op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] store_data;
        logic [4:0]  dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_data;
        logic [4:0]  dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] load_data;
        logic [4:0]  dst;
        logic        reg_write;
        logic        mem_read;
    } mem_wb_t;

endpackage

// File: rtl/cpu_alu.sv
// 32-bit ALU: wrapping add/sub, bitwise and/or, signed set-less-than.
module cpu_alu
    import cpu_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    always_comb begin
        y = '0;
        unique case (op)
            AluAdd: y = a + b;
            AluSub: y = a - b;
            AluAnd: y = a & b;
            AluOr:  y = a | b;
            AluSlt: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/cpu_ex.sv
// Execute stage: ALU evaluation, control and store data passed through.
module cpu_ex
    import cpu_pkg::*;
(
    input  id_ex_t  de,
    output ex_mem_t em
);
    logic [31:0] alu_y;

    cpu_alu u_alu (
        .op (de.alu_op),
        .a  (de.a),
        .b  (de.b),
        .y  (alu_y)
    );

    always_comb begin
        em            = '0;
        em.alu_res    = alu_y;
        em.store_data = de.store_data;
        em.dst        = de.dst;
        em.reg_write  = de.reg_write;
        em.mem_read   = de.mem_read;
        em.mem_write  = de.mem_write;
    end

endmodule

// File: rtl/cpu_id.sv
// Decode stage: field extraction, control decode and the register file.
module cpu_id
    import cpu_pkg::*;
(
    input  logic        clk,
    input  if_id_t      fd,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output id_ex_t      de
);
    logic [31:0] REG [0:31];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [31:0] simm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    assign opcode = fd.instr[31:26];
    assign rs     = fd.instr[25:21];
    assign rt     = fd.instr[20:16];
    assign imm    = fd.instr[15:0];
    assign simm   = {{16{imm[15]}}, imm};

    // Reads are not write-through; software spaces dependent instructions.
    assign rs_val = (rs == 5'd0) ? 32'd0 : REG[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : REG[rt];

    always_ff @(posedge clk) begin
        if (wb_en && (wb_addr != 5'd0)) begin
            REG[wb_addr] <= wb_data;
        end
    end

    // Anything not recognised falls through with all write enables low.
    always_comb begin
        de            = '0;
        de.alu_op     = AluAdd;
        de.a          = rs_val;
        de.b          = rt_val;
        de.store_data = rt_val;
        case (opcode)
            OP_RTYPE: begin
                de.dst = imm[15:11];
                case (imm[5:0])
                    FN_ADD: begin de.alu_op = AluAdd; de.reg_write = 1'b1; end
                    FN_SUB: begin de.alu_op = AluSub; de.reg_write = 1'b1; end
                    FN_AND: begin de.alu_op = AluAnd; de.reg_write = 1'b1; end
                    FN_OR:  begin de.alu_op = AluOr;  de.reg_write = 1'b1; end
                    FN_SLT: begin de.alu_op = AluSlt; de.reg_write = 1'b1; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                de.b         = simm;
                de.dst       = rt;
                de.reg_write = 1'b1;
            end
            OP_LW: begin
                de.b         = simm;
                de.dst       = rt;
                de.reg_write = 1'b1;
                de.mem_read  = 1'b1;
            end
            OP_SW: begin
                de.b         = simm;
                de.mem_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_if.sv
// Fetch stage: program counter and instruction memory (loaded externally).
module cpu_if #(
    parameter int unsigned IM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    output logic [31:0] instr
);
    localparam int unsigned IW = $clog2(IM_WORDS);
    localparam logic [31:0] PC_MASK = 32'(IM_WORDS * 4 - 1);

    logic [31:0] PC;
    logic [31:0] instruction [0:IM_WORDS-1];

    // No stalls: the PC advances every cycle and wraps over the instruction memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC <= '0;
        end else begin
            PC <= (PC + 32'd4) & PC_MASK;
        end
    end

    assign pc    = PC;
    assign instr = instruction[PC[IW+1:2]];

endmodule

// File: rtl/cpu_mem.sv
// Memory stage: data memory with clocked store and combinational load.
module cpu_mem
    import cpu_pkg::*;
#(
    parameter int unsigned DM_WORDS = 128
) (
    input  logic    clk,
    input  ex_mem_t em,
    output mem_wb_t mw
);
    localparam int unsigned AW = $clog2(DM_WORDS);

    logic [31:0]   DM [0:DM_WORDS-1];
    logic [AW-1:0] addr;

    // Upper address bits are dropped, so out-of-range addresses alias.
    assign addr = em.alu_res[AW+1:2];

    always_ff @(posedge clk) begin
        if (em.mem_write) begin
            DM[addr] <= em.store_data;
        end
    end

    always_comb begin
        mw           = '0;
        mw.alu_res   = em.alu_res;
        mw.load_data = DM[addr];
        mw.dst       = em.dst;
        mw.reg_write = em.reg_write;
        mw.mem_read  = em.mem_read;
    end

endmodule

// File: rtl/cpu_wb.sv
// Write-back stage: selects load data or ALU result for the register file.
module cpu_wb
    import cpu_pkg::*;
(
    input  mem_wb_t     mw,
    output logic        en,
    output logic [4:0]  addr,
    output logic [31:0] data
);
    assign en   = mw.reg_write;
    assign addr = mw.dst;
    assign data = mw.mem_read ? mw.load_data : mw.alu_res;

endmodule

// File: rtl/cpu.sv
// Five-stage in-order MIPS-subset core; no forwarding or hazard detection.
module cpu
    import cpu_pkg::*;
#(
    parameter int unsigned IM_WORDS = 128,
    parameter int unsigned DM_WORDS = 128
) (
    input logic clk,
    input logic rst
);
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] FD_PC;

    if_id_t  fd;
    id_ex_t  de_d;
    id_ex_t  de;
    ex_mem_t em_d;
    ex_mem_t em;
    mem_wb_t mw_d;
    mem_wb_t mw;

    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    cpu_if #(.IM_WORDS(IM_WORDS)) IF (
        .clk   (clk),
        .rst   (rst),
        .pc    (pc),
        .instr (instr)
    );

    cpu_id ID (
        .clk     (clk),
        .fd      (fd),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .de      (de_d)
    );

    cpu_ex EX (
        .de (de),
        .em (em_d)
    );

    cpu_mem #(.DM_WORDS(DM_WORDS)) MEM (
        .clk (clk),
        .em  (em),
        .mw  (mw_d)
    );

    cpu_wb WB (
        .mw   (mw),
        .en   (wb_en),
        .addr (wb_addr),
        .data (wb_data)
    );

    // Clearing every stage on reset squashes in-flight instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            FD_PC <= '0;
            fd    <= '0;
            de    <= '0;
            em    <= '0;
            mw    <= '0;
        end else begin
            FD_PC    <= pc;
            fd.instr <= instr;
            de       <= de_d;
            em       <= em_d;
            mw       <= mw_d;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed vector table, timing sequences and
// random programs checked against an instruction-level reference model.
module tb_cpu;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cpu #(.IM_WORDS(128), .DM_WORDS(128)) dut (
        .clk (clk),
        .rst (rst)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [0:127];
    logic [31:0] mreg [0:31];
    logic [31:0] mdm  [0:127];

    typedef struct {
        logic [31:0] instr;
        logic        is_mem;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Instruction-set reference: executes one word with sequential semantics.
    task automatic iss(input logic [31:0] w);
        int          rs;
        int          rt;
        int          rd;
        int          widx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] simm;
        rs   = int'(w[25:21]);
        rt   = int'(w[20:16]);
        rd   = int'(w[15:11]);
        simm = {{16{w[15]}}, w[15:0]};
        a    = mreg[rs];
        b    = mreg[rt];
        widx = int'(((a + simm) >> 2) % 32'd128);
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h20: mreg[rd] = a + b;
                6'h22: mreg[rd] = a - b;
                6'h24: mreg[rd] = a & b;
                6'h25: mreg[rd] = a | b;
                6'h2A: mreg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: ;
            endcase
            6'h08: mreg[rt] = a + simm;
            6'h23: mreg[rt] = mdm[widx];
            6'h2B: mdm[widx] = b;
            default: ;
        endcase
        mreg[0] = 32'd0;
    endtask

    function automatic logic [31:0] rand_instr();
        int          kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [5:0]  op;
        logic [5:0]  fn;
        kind = $urandom_range(0, 9);
        rs   = 5'($urandom);
        rt   = 5'($urandom);
        rd   = 5'($urandom);
        imm  = 16'($urandom);
        case (kind)
            0: return r_op(rd, rs, rt, 6'h20);
            1: return r_op(rd, rs, rt, 6'h22);
            2: return r_op(rd, rs, rt, 6'h24);
            3: return r_op(rd, rs, rt, 6'h25);
            4: return r_op(rd, rs, rt, 6'h2A);
            5: return i_op(6'h08, rt, rs, imm);
            6: return i_op(6'h23, rt, rs, imm);
            7: return i_op(6'h2B, rt, rs, imm);
            8: begin
                fn = 6'($urandom);
                if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) fn = 6'h3F;
                return r_op(rd, rs, rt, fn);
            end
            default: begin
                op = 6'($urandom_range(1, 63));
                if (op inside {6'h08, 6'h23, 6'h2B}) op = 6'h3F;
                return {op, 26'($urandom)};
            end
        endcase
    endfunction

    task automatic push_dut();
        for (int i = 0; i < 128; i++) dut.IF.instruction[i] <= prog[i];
        for (int i = 0; i < 32; i++) dut.ID.REG[i] <= mreg[i];
        for (int i = 0; i < 128; i++) dut.MEM.DM[i] <= mdm[i];
    endtask

    // Reset, preload, then release mid low phase; the next rising edge ends cycle 0.
    task automatic load_and_start();
        @(negedge clk);
        rst = 1'b1;
        push_dut();
        #2 rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #5;
    endtask

    task automatic clear_images();
        for (int i = 0; i < 128; i++) prog[i] = 32'd0;
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0101_0101 * 32'(i);
        for (int i = 0; i < 128; i++) mdm[i] = 32'hD000_0000 + 32'(i);
        mreg[0] = 32'd0;
    endtask

    initial begin
        // Reset and sequential fetch, including PC wrap.
        clear_images();
        mreg[1] = 32'd1;
        mdm[0]  = 32'd9;
        push_dut();
        #5;
        check("reset_pc", dut.IF.PC, 32'd0);
        check("reset_fd_pc", dut.FD_PC, 32'd0);
        #7 rst = 1'b0;
        @(negedge clk);
        check("fetch_c0", dut.FD_PC >> 2, 32'd0);
        for (int k = 1; k <= 131; k++) begin
            @(negedge clk);
            check($sformatf("fetch_c%0d", k), dut.FD_PC >> 2, 32'((k - 1) % 128));
        end
        check("preload_reg1", dut.ID.REG[1], 32'd1);
        check("preload_dm0", dut.MEM.DM[0], 32'd9);

        // Add chain with write-back timing.
        clear_images();
        mreg[1] = 32'd1;
        mreg[2] = 32'd2;
        mreg[3] = 32'h0000_DEAD;
        mdm[0]  = 32'd9;
        mdm[1]  = 32'd3;
        prog[0]  = r_op(5'd3, 5'd1, 5'd2, 6'h20);
        prog[4]  = r_op(5'd5, 5'd3, 5'd0, 6'h20);
        prog[8]  = r_op(5'd3, 5'd3, 5'd5, 6'h20);
        prog[12] = r_op(5'd4, 5'd3, 5'd5, 6'h20);
        load_and_start();
        run(4);
        check("chain_reg3_before_wb", dut.ID.REG[3], 32'h0000_DEAD);
        run(1);
        check("chain_reg3_first_wb", dut.ID.REG[3], 32'd3);
        run(15);
        check("chain_reg3", dut.ID.REG[3], 32'd6);
        check("chain_reg4", dut.ID.REG[4], 32'd9);
        check("chain_reg5", dut.ID.REG[5], 32'd3);
        check("chain_dm0", dut.MEM.DM[0], 32'd9);
        check("chain_dm1", dut.MEM.DM[1], 32'd3);

        // Mid-program reset discards in-flight instructions.
        clear_images();
        mreg[1] = 32'd1;
        mreg[2] = 32'd2;
        mreg[3] = 32'h0000_DEAD;
        mreg[4] = 32'h0000_BEEF;
        prog[0] = r_op(5'd3, 5'd1, 5'd2, 6'h20);
        prog[1] = r_op(5'd4, 5'd1, 5'd1, 6'h20);
        load_and_start();
        run(3);
        rst = 1'b1;
        #1;
        check("midrst_pc", dut.IF.PC, 32'd0);
        check("midrst_fd_pc", dut.FD_PC, 32'd0);
        run(3);
        check("midrst_reg3", dut.ID.REG[3], 32'h0000_DEAD);
        check("midrst_reg4", dut.ID.REG[4], 32'h0000_BEEF);

        // Directed vector table, each entry spaced by three NOPs, then illegal words.
        vecs[0]  = '{r_op(5'd7, 5'd1, 5'd2, 6'h22), 1'b0, 7, 32'hFFFF_FFFF};
        vecs[1]  = '{r_op(5'd8, 5'd7, 5'd1, 6'h2A), 1'b0, 8, 32'd1};
        vecs[2]  = '{r_op(5'd9, 5'd1, 5'd2, 6'h24), 1'b0, 9, 32'd0};
        vecs[3]  = '{r_op(5'd10, 5'd1, 5'd2, 6'h25), 1'b0, 10, 32'd3};
        vecs[4]  = '{i_op(6'h08, 5'd11, 5'd0, 16'hFFFF), 1'b0, 11, 32'hFFFF_FFFF};
        vecs[5]  = '{r_op(5'd0, 5'd1, 5'd2, 6'h20), 1'b0, 0, 32'd0};
        vecs[6]  = '{i_op(6'h23, 5'd6, 5'd0, 16'h0004), 1'b0, 6, 32'd3};
        vecs[7]  = '{i_op(6'h2B, 5'd6, 5'd0, 16'h0008), 1'b1, 2, 32'd3};
        vecs[8]  = '{r_op(5'd14, 5'd13, 5'd1, 6'h20), 1'b0, 14, 32'h8000_0000};
        vecs[9]  = '{r_op(5'd15, 5'd13, 5'd14, 6'h2A), 1'b0, 15, 32'd0};
        vecs[10] = '{r_op(5'd16, 5'd14, 5'd13, 6'h2A), 1'b0, 16, 32'd1};
        vecs[11] = '{i_op(6'h23, 5'd17, 5'd18, 16'hFFFC), 1'b0, 17, 32'h1234_5678};
        vecs[12] = '{i_op(6'h23, 5'd19, 5'd0, 16'h0204), 1'b0, 19, 32'd3};
        vecs[13] = '{i_op(6'h2B, 5'd13, 5'd0, 16'h0214), 1'b1, 5, 32'h7FFF_FFFF};
        vecs[14] = '{i_op(6'h08, 5'd22, 5'd1, 16'h7FFF), 1'b0, 22, 32'h0000_8000};
        clear_images();
        mreg[1]  = 32'd1;
        mreg[2]  = 32'd2;
        mreg[13] = 32'h7FFF_FFFF;
        mreg[18] = 32'd16;
        mdm[0]   = 32'd9;
        mdm[1]   = 32'd3;
        mdm[3]   = 32'h1234_5678;
        for (int k = 0; k < 15; k++) prog[4 * k] = vecs[k].instr;
        prog[60] = r_op(5'd20, 5'd1, 5'd2, 6'h21);
        prog[61] = i_op(6'h0D, 5'd21, 5'd1, 16'h00FF);
        prog[62] = 32'hFFFF_FFFF;
        prog[63] = {6'h2F, 5'd0, 5'd23, 16'h0010};
        prog[64] = {6'h3F, 26'h3FF_FFFF};
        load_and_start();
        run(80);
        for (int k = 0; k < 15; k++) begin
            if (vecs[k].is_mem)
                check($sformatf("vec%0d_dm[%0d]", k, vecs[k].idx),
                      dut.MEM.DM[vecs[k].idx], vecs[k].exp);
            else
                check($sformatf("vec%0d_reg[%0d]", k, vecs[k].idx),
                      dut.ID.REG[vecs[k].idx], vecs[k].exp);
        end
        check("illegal_reg20", dut.ID.REG[20], 32'h1414_1414);
        check("illegal_reg21", dut.ID.REG[21], 32'h1515_1515);
        check("illegal_reg23", dut.ID.REG[23], 32'h1717_1717);
        check("illegal_dm4", dut.MEM.DM[4], 32'hD000_0004);
        check("illegal_dm127", dut.MEM.DM[127], 32'hD000_007F);

        // Random programs against the instruction-level model.
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 128; i++) prog[i] = 32'd0;
            for (int i = 0; i < 32; i++) mreg[i] = $urandom;
            for (int i = 0; i < 128; i++) mdm[i] = $urandom;
            mreg[0] = 32'd0;
            for (int k = 0; k < 24; k++) prog[4 * k] = rand_instr();
            load_and_start();
            for (int k = 0; k < 128; k++) iss(prog[k]);
            run(105);
            for (int i = 0; i < 32; i++)
                check($sformatf("rand%0d_reg[%0d]", it, i), dut.ID.REG[i], mreg[i]);
            for (int i = 0; i < 128; i++)
                check($sformatf("rand%0d_dm[%0d]", it, i), dut.MEM.DM[i], mdm[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
